// File: rtl/tlb_op_seq.sv
// Sequencer for the CP0 TLB instructions (TLBP/TLBR/TLBWI/TLBWR): drives the TLB
// write strobe and address, stalls translation while busy, and owns the CP0 Random register.
module tlb_op_seq #(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [IDX_W-1:0] req_index,
    input  logic [IDX_W-1:0] wired,
    input  logic             probe_hit,
    input  logic [IDX_W-1:0] probe_index,
    output logic             tlbw_valid,
    output logic [IDX_W-1:0] tlb_addr,
    output logic             trans_stall,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [IDX_W:0]   resp_index,
    output logic             resp_load_hilo,
    output logic [IDX_W-1:0] random,
    output logic [1:0]       o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; once resp_valid rises, every resp_* output holds until resp_ready is seen.

    localparam logic [1:0] OP_TLBP  = 2'd0;
    localparam logic [1:0] OP_TLBR  = 2'd1;
    localparam logic [1:0] OP_TLBWI = 2'd2;
    localparam logic [1:0] OP_TLBWR = 2'd3;

    // TLB_ENTRIES is a power of two, so the top entry index is all ones.
    localparam logic [IDX_W-1:0] LP_MAX = {IDX_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXEC   = 2'd1,
        S_SETTLE = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_op;
    logic [IDX_W-1:0] r_index;
    logic [IDX_W-1:0] r_addr;
    logic [IDX_W:0]   r_resp_index;
    logic [IDX_W-1:0] r_random;
    logic [IDX_W-1:0] w_rand_dec;
    logic [IDX_W-1:0] w_rand_next;
    logic             w_accept;
    logic             w_is_write;

    assign w_is_write = (r_op == OP_TLBWI) || (r_op == OP_TLBWR);
    assign w_rand_dec = r_random - 1'b1;

    // Random never steps into the wired region: it reloads instead of reaching wired.
    always_comb begin
        w_rand_next = w_rand_dec;
        if ((wired >= LP_MAX) || (r_random <= wired) || (w_rand_dec <= wired)) begin
            w_rand_next = LP_MAX;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_accept       = 1'b0;
        req_ready      = 1'b0;
        tlbw_valid     = 1'b0;
        resp_valid     = 1'b0;
        resp_load_hilo = 1'b0;
        trans_stall    = 1'b1;
        case (r_state)
            S_IDLE: begin
                req_ready   = 1'b1;
                trans_stall = 1'b0;
                if (req_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_EXEC;
                end
            end
            S_EXEC: begin
                tlbw_valid = w_is_write;
                w_next     = w_is_write ? S_SETTLE : S_RESP;
            end
            S_SETTLE: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                resp_valid     = 1'b1;
                resp_load_hilo = (r_op == OP_TLBR);
                if (resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_random     <= LP_MAX;
            r_op         <= OP_TLBP;
            r_index      <= '0;
            r_addr       <= '0;
            r_resp_index <= '0;
        end else begin
            r_state  <= w_next;
            r_random <= w_rand_next;
            if (w_accept) begin
                r_op    <= req_op;
                r_index <= req_index;
                // TLBWR takes the Random value visible in the accept cycle.
                r_addr  <= (req_op == OP_TLBWR) ? r_random : req_index;
            end
            if (r_state == S_EXEC) begin
                case (r_op)
                    OP_TLBP: r_resp_index <= {~probe_hit, probe_index};
                    OP_TLBR: r_resp_index <= {1'b0, r_index};
                    default: r_resp_index <= {1'b0, r_addr};
                endcase
            end
        end
    end

    assign tlb_addr    = r_addr;
    assign resp_index  = r_resp_index;
    assign random      = r_random;
    assign o_dbg_state = r_state;

endmodule

// File: doc/tlb_op_seq.md
TLB_OP_SEQ -- requirements
Module: tlb_op_seq

Interface
REQ-001 SHALL have parameter TLB_ENTRIES, default 16: number of TLB entries; power of two, at least 2.
REQ-002 SHALL have parameter IDX_W, default 4: index width, equal to log2(TLB_ENTRIES).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1 bit: a TLB operation request is present.
REQ-006 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-007 SHALL have port req_op, input, 2 bits: operation code; 0=TLBP, 1=TLBR, 2=TLBWI, 3=TLBWR.
REQ-008 SHALL have port req_index, input, IDX_W bits: CP0 Index value, used by TLBR and TLBWI.
REQ-009 SHALL have port wired, input, IDX_W bits: CP0 Wired value.
REQ-010 SHALL have port probe_hit, input, 1 bit: TLB probe result, combinational, valid in EXEC.
REQ-011 SHALL have port probe_index, input, IDX_W bits: index of the probe hit.
REQ-012 SHALL have port tlbw_valid, output, 1 bit: one-cycle TLB write strobe.
REQ-013 SHALL have port tlb_addr, output, IDX_W bits: address used for the TLB write and read.
REQ-014 SHALL have port trans_stall, output, 1 bit: freezes I/D address translation consumers.
REQ-015 SHALL have port resp_valid, output, 1 bit: the response is present.
REQ-016 SHALL have port resp_ready, input, 1 bit: the consumer accepts the response.
REQ-017 SHALL have port resp_index, output, IDX_W+1 bits: bit IDX_W is P (probe miss) and the low bits are the index.
REQ-018 SHALL have port resp_load_hilo, output, 1 bit: CP0 captures EntryHi/Lo from the TLB read data (TLBR only).
REQ-019 SHALL have port random, output, IDX_W bits: current CP0 Random value.

Function
REQ-020 SHALL implement FSM states IDLE, EXEC, SETTLE and RESP.
REQ-021 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both high.
REQ-022 SHALL latch op, index and the address on accept, then move IDLE->EXEC.
  - Address: req_index for TLBP, TLBR and TLBWI; random for TLBWR.
REQ-023 SHALL, in EXEC, drive tlb_addr from the latched address.
  - TLBWI/TLBWR: tlbw_valid=1 for exactly this cycle, then EXEC->SETTLE.
  - TLBP: capture {~probe_hit, probe_index}, then EXEC->RESP.
  - TLBR: capture {1'b0, latched index}, then EXEC->RESP.
REQ-024 SHALL spend exactly one cycle in SETTLE, so the TLB's registered lookup flags reflect the new entry, then move SETTLE->RESP.
REQ-025 SHALL hold resp_valid=1 in RESP; all response outputs stay stable until resp_ready=1, then RESP->IDLE.
REQ-026 SHALL give resp_load_hilo=1 only in RESP for TLBR; for writes resp_index SHALL be {1'b0, written address}.
REQ-027 SHALL assert trans_stall whenever the state is not IDLE.
REQ-028 SHALL give accept-to-resp_valid latencies of 2 cycles for TLBP/TLBR and 3 cycles for TLBWI/TLBWR (with resp_ready held high).
REQ-029 SHALL have tlbw_valid=0 in every state except EXEC with a write op.
REQ-030 SHALL update random every cycle.
  - Decrement by 1.
  - If random <= wired, load TLB_ENTRIES-1 instead.
  - If wired >= TLB_ENTRIES-1, hold at TLB_ENTRIES-1.
REQ-031 SHALL, when TLBWR is accepted, use the random value sampled in the accept cycle; later changes to random do not affect that write.
REQ-032 SHALL ignore req_valid outside IDLE, with no queueing.
REQ-033 SHALL keep out-of-range conditions impossible: all index arithmetic is modulo 2^IDX_W.

Reset
REQ-034 SHALL, while resetn=0 (asynchronous), force: state=IDLE, random=TLB_ENTRIES-1, tlbw_valid=0, resp_valid=0, resp_load_hilo=0, resp_index=0, trans_stall=0, req_ready=1.
REQ-035 SHALL, on reset mid-operation, abandon any pending write strobe or response; no tlbw_valid pulse after resetn rises unless a new request is accepted.

Verification
REQ-036 SHALL pass: TLBWI with req_index=5 -> tlbw_valid=1 and tlb_addr=5 one cycle after accept, resp_valid 3 cycles after accept, resp_index=0x05.
REQ-037 SHALL pass: TLBP with probe_hit=0 -> resp_index=0x10 after 2 cycles; with probe_hit=1 and probe_index=9 -> resp_index=0x09.
REQ-038 SHALL pass: wired=3 and free-running counter -> random sequence 15,14,...,4,15 repeats, never below 4.
REQ-039 SHALL pass: resp_ready held 0 for 4 cycles in RESP -> resp_valid and resp_index stable, trans_stall=1, req_ready=0, a second req_valid ignored.
REQ-040 SHALL pass: resetn pulled low during SETTLE -> all outputs at reset values immediately, req_ready=1, random=15.
REQ-041 SHALL pass: TLBR with req_index=7 -> tlb_addr=7 in EXEC, resp_load_hilo=1 in RESP only, resp_index=0x07.
